load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the ALU.
- Takes the ALU RESULT as the effective address for RV32I loads and stores, plus rs2 store data.
- Runs a request/acknowledge transaction with the data memory and stalls the pipeline while the transaction is in flight.
- Returns load data that is aligned and sign- or zero-extended, and flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT, 64, maximum cycles spent waiting for DMEM_ACK before the access is aborted (range 1..255).

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous reset, active-low
- MEM_READ  input  1  load request from pipeline control
- MEM_WRITE  input  1  store request from pipeline control; has priority if both are high
- FUNCT3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ADDRESS  input  32  effective address (ALU RESULT)
- WRITE_DATA  input  32  store data (rs2)
- BUSYWAIT  output  1  pipeline stall request
- READ_DATA  output  32  formatted load result
- LOAD_VALID  output  1  one-cycle pulse: READ_DATA is valid
- MISALIGNED  output  1  one-cycle pulse: access rejected
- BUS_ERROR  output  1  one-cycle pulse: ACK timeout
- DMEM_REQ  output  1  memory request
- DMEM_WE  output  1  1 = write
- DMEM_ADDR  output  32  word address, {ADDRESS[31:2],2'b00}
- DMEM_WDATA  output  32  lane-replicated store data
- DMEM_BE  output  4  byte enables
- DMEM_RDATA  input  32  memory read word
- DMEM_ACK  input  1  memory completion, sampled on the rising edge

Behaviour:
- Reset (RESET low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0; DMEM_REQ drops immediately, including in the middle of ACCESS.
  - The timeout counter clears.
- States are IDLE, ACCESS and DONE.
- Request and alignment check in IDLE:
  - A request is MEM_READ or MEM_WRITE.
  - W needs ADDRESS[1:0]=00. H/HU need ADDRESS[0]=0.
  - Illegal FUNCT3: loads 011/110/111; stores anything other than 000/001/010.
  - A misaligned or illegal request gets MISALIGNED=1 for one cycle (registered, next cycle). No memory request is made, BUSYWAIT stays 0, and state stays IDLE.
- Valid request in IDLE:
  - BUSYWAIT=1 combinationally in the same cycle.
  - At the edge, DMEM_ADDR/WDATA/BE/WE are registered, DMEM_REQ is set, and state goes to ACCESS.
- ACCESS:
  - BUSYWAIT=1.
  - DMEM_REQ, ADDR, WDATA, BE and WE are held stable.
  - Pipeline inputs are ignored.
  - The counter increments every cycle.
- DMEM_ACK=1 at an edge in ACCESS:
  - DMEM_REQ goes to 0 and state goes to DONE.
  - For a load, the formatted DMEM_RDATA is captured into READ_DATA.
- Counter reaches TIMEOUT without an ACK:
  - DMEM_REQ goes to 0, BUS_ERROR pulses, READ_DATA is set to 0, and state goes to DONE.
- DONE:
  - BUSYWAIT=0, so the pipeline advances on this edge.
  - LOAD_VALID=1 for a completed load (not for a store and not for a timeout).
  - Inputs present in DONE belong to the completed operation and are ignored.
  - DONE goes to IDLE unconditionally.
- Latency:
  - Minimum 3 cycles per access: request cycle, ACCESS with ACK, then DONE.
  - Each ACCESS wait cycle adds one.
- A late ACK arriving after a timeout or outside ACCESS is ignored.
- Store formatting (o = ADDRESS[1:0]):
  - SB: WDATA = {4{WRITE_DATA[7:0]}}, BE = 4'b0001 << o.
  - SH: WDATA = {2{WRITE_DATA[15:0]}}, BE = 4'b0011 << {o[1],1'b0}.
  - SW: WDATA = WRITE_DATA, BE = 4'b1111.
- Loads drive DMEM_WE=0 and DMEM_BE=1111.
- Load formatting:
  - Select byte o or halfword o[1] from DMEM_RDATA.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Outputs outside a transaction:
  - READ_DATA holds until the next completed load or timeout.
  - DMEM_ADDR/WDATA/BE hold their last values when DMEM_REQ=0.

Test Plan:
1. Reset mid-ACCESS (SW in flight, RESET pulsed low between edges) -> DMEM_REQ drops immediately, BUSYWAIT=0, all outputs 0; after release a new LW completes normally.
2. LB at ADDRESS=0x1003, DMEM_RDATA=0x80FF_0011, ACK on the first ACCESS cycle -> DMEM_ADDR=0x1000, BUSYWAIT high for 2 cycles, READ_DATA=0xFFFFFF80, LOAD_VALID one pulse in DONE.
3. LHU at 0x2002 then LH at 0x2002, DMEM_RDATA=0x9ABC_1234, ACK after 3 wait cycles -> READ_DATA=0x00009ABC then 0xFFFF9ABC; BUSYWAIT lasts 5 cycles each.
4. SB at 0x3001 with WRITE_DATA=0x000000A5 -> DMEM_WE=1, DMEM_BE=0010, DMEM_WDATA=0xA5A5A5A5; SH at 0x3002 -> DMEM_BE=1100; LOAD_VALID stays 0.
5. SW at 0x4002, then LH at 0x4001, then a load with FUNCT3=011 -> MISALIGNED pulses each time, no DMEM_REQ, BUSYWAIT stays 0.
6. TIMEOUT=4, LW with ACK held low -> DMEM_REQ high for 4 cycles, BUS_ERROR pulse, READ_DATA=0, LOAD_VALID=0; an ACK arriving 2 cycles later is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns an ALU effective address into one request/acknowledge
// transaction on the data memory, stalls the pipeline meanwhile and returns formatted load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic        BUSYWAIT,
    output logic [31:0] READ_DATA,
    output logic        LOAD_VALID,
    output logic        MISALIGNED,
    output logic        BUS_ERROR,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    output logic [3:0]  DMEM_BE,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_ACK
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    // Extract the addressed byte/halfword from a memory word and extend it.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b100:  fmt_load = {24'd0, b};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = word;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  store_be = 4'b0001 << off;
            3'b001:  store_be = 4'b0011 << {off[1], 1'b0};
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
        case (f3)
            3'b000:  store_wdata = {4{data[7:0]}};
            3'b001:  store_wdata = {2{data[15:0]}};
            default: store_wdata = data;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        load_valid_q, load_valid_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_error_q, bus_error_d;
    logic        busy_s;
    logic        req_s;
    logic        legal_s;
    logic        aligned_s;

    // Request decode: legality of FUNCT3 for the access direction and natural alignment.
    always_comb begin
        req_s = MEM_READ | MEM_WRITE;
        if (MEM_WRITE) begin
            legal_s = (FUNCT3 == 3'b000) || (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010);
        end else begin
            legal_s = !((FUNCT3 == 3'b011) || (FUNCT3 == 3'b110) || (FUNCT3 == 3'b111));
        end
        case (FUNCT3[1:0])
            2'b10:   aligned_s = (ADDRESS[1:0] == 2'b00);
            2'b01:   aligned_s = (ADDRESS[0] == 1'b0);
            default: aligned_s = 1'b1;
        endcase
    end

    // Next-state and output logic for the IDLE/ACCESS/DONE transaction sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        f3_d         = f3_q;
        off_d        = off_q;
        rdata_d      = rdata_q;
        load_valid_d = 1'b0;
        misaligned_d = 1'b0;
        bus_error_d  = 1'b0;
        busy_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_s && legal_s && aligned_s) begin
                    busy_s  = 1'b1;
                    state_d = S_ACCESS;
                    cnt_d   = 8'd0;
                    req_d   = 1'b1;
                    we_d    = MEM_WRITE;
                    addr_d  = {ADDRESS[31:2], 2'b00};
                    f3_d    = FUNCT3;
                    off_d   = ADDRESS[1:0];
                    if (MEM_WRITE) begin
                        wdata_d = store_wdata(FUNCT3, WRITE_DATA);
                        be_d    = store_be(FUNCT3, ADDRESS[1:0]);
                    end else begin
                        be_d    = 4'b1111;
                    end
                end else if (req_s) begin
                    misaligned_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                busy_s = 1'b1;
                // An ACK on the final allowed cycle still completes the access.
                if (DMEM_ACK) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d      = fmt_load(f3_q, off_q, DMEM_RDATA);
                        load_valid_d = 1'b1;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    req_d       = 1'b0;
                    bus_error_d = 1'b1;
                    rdata_d     = 32'd0;
                    cnt_d       = 8'd0;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            rdata_q      <= 32'd0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            rdata_q      <= rdata_d;
            load_valid_q <= load_valid_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
        end
    end

    // The stall must be visible in the request cycle itself, so it is combinational.
    assign BUSYWAIT   = busy_s & RESET;
    assign READ_DATA  = rdata_q;
    assign LOAD_VALID = load_valid_q;
    assign MISALIGNED = misaligned_q;
    assign BUS_ERROR  = bus_error_q;
    assign DMEM_REQ   = req_q;
    assign DMEM_WE    = we_q;
    assign DMEM_ADDR  = addr_q;
    assign DMEM_WDATA = wdata_q;
    assign DMEM_BE    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single accesses plus hand sequences
// for reset during ACCESS and the bus timeout.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ, MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS, WRITE_DATA, DMEM_RDATA;
    logic        DMEM_ACK;

    logic        BUSYWAIT, LOAD_VALID, MISALIGNED, BUS_ERROR, DMEM_REQ, DMEM_WE;
    logic [31:0] READ_DATA, DMEM_ADDR, DMEM_WDATA;
    logic [3:0]  DMEM_BE;

    logic        t_BUSYWAIT, t_LOAD_VALID, t_MISALIGNED, t_BUS_ERROR, t_DMEM_REQ, t_DMEM_WE;
    logic [31:0] t_READ_DATA, t_DMEM_ADDR, t_DMEM_WDATA;
    logic [3:0]  t_DMEM_BE;

    int errors = 0;
    int checks = 0;
    logic [31:0] prev_rd;

    always #5 CLK = ~CLK;

    load_store_unit dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .FUNCT3(FUNCT3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .BUSYWAIT(BUSYWAIT), .READ_DATA(READ_DATA), .LOAD_VALID(LOAD_VALID),
        .MISALIGNED(MISALIGNED), .BUS_ERROR(BUS_ERROR), .DMEM_REQ(DMEM_REQ),
        .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
        .DMEM_BE(DMEM_BE), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK)
    );

    load_store_unit #(.TIMEOUT(4)) dut_to (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .FUNCT3(FUNCT3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .BUSYWAIT(t_BUSYWAIT), .READ_DATA(t_READ_DATA), .LOAD_VALID(t_LOAD_VALID),
        .MISALIGNED(t_MISALIGNED), .BUS_ERROR(t_BUS_ERROR), .DMEM_REQ(t_DMEM_REQ),
        .DMEM_WE(t_DMEM_WE), .DMEM_ADDR(t_DMEM_ADDR), .DMEM_WDATA(t_DMEM_WDATA),
        .DMEM_BE(t_DMEM_BE), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          waits;
        logic        mis;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        FUNCT3     = 3'b111;
        ADDRESS    = 32'hDEAD_BEEF;
        WRITE_DATA = 32'hFFFF_FFFF;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(DMEM_REQ), 32'd0);
        chk({tag, "_busy"},  32'(BUSYWAIT), 32'd0);
        chk({tag, "_we"},    32'(DMEM_WE), 32'd0);
        chk({tag, "_addr"},  DMEM_ADDR, 32'd0);
        chk({tag, "_wdata"}, DMEM_WDATA, 32'd0);
        chk({tag, "_be"},    32'(DMEM_BE), 32'd0);
        chk({tag, "_rdata"}, READ_DATA, 32'd0);
        chk({tag, "_flags"}, {29'd0, LOAD_VALID, MISALIGNED, BUS_ERROR}, 32'd0);
        chk({tag, "_to_req"}, {31'd0, t_DMEM_REQ}, 32'd0);
    endtask

    // One access from IDLE; entered and left at posedge+1.
    task automatic run_access(input vec_t v, input int idx);
        int busy;
        int reqc;
        string p;
        busy = 0;
        reqc = 0;
        p = $sformatf("v%0d", idx);
        MEM_WRITE  = v.st;
        MEM_READ   = !v.st;
        FUNCT3     = v.f3;
        ADDRESS    = v.addr;
        WRITE_DATA = v.wd;
        DMEM_RDATA = v.rd;
        DMEM_ACK   = 1'b0;
        #1;
        if (v.mis) begin
            chk({p, "_busy_req"}, 32'(BUSYWAIT), 32'd0);
            @(posedge CLK); #1;
            idle_inputs();
            #1;
            chk({p, "_mis"}, 32'(MISALIGNED), 32'd1);
            chk({p, "_noreq"}, 32'(DMEM_REQ), 32'd0);
            chk({p, "_busy"}, 32'(BUSYWAIT), 32'd0);
            chk({p, "_rd_hold"}, READ_DATA, prev_rd);
            @(posedge CLK); #1;
            chk({p, "_mis_end"}, 32'(MISALIGNED), 32'd0);
        end else begin
            if (BUSYWAIT) busy++;
            @(posedge CLK); #1;
            idle_inputs();
            for (int w = 0; w <= v.waits; w++) begin
                DMEM_ACK = (w == v.waits);
                #1;
                if (BUSYWAIT) busy++;
                if (DMEM_REQ) reqc++;
                @(posedge CLK); #1;
            end
            DMEM_ACK = 1'b0;
            #1;
            if (!v.st) prev_rd = v.exp_rd;
            chk({p, "_busy_cycles"}, 32'(busy), 32'(v.waits + 2));
            chk({p, "_req_cycles"}, 32'(reqc), 32'(v.waits + 1));
            chk({p, "_busy_done"}, 32'(BUSYWAIT), 32'd0);
            chk({p, "_req_done"}, 32'(DMEM_REQ), 32'd0);
            chk({p, "_valid"}, 32'(LOAD_VALID), 32'(!v.st));
            chk({p, "_rdata"}, READ_DATA, prev_rd);
            chk({p, "_addr"}, DMEM_ADDR, {v.addr[31:2], 2'b00});
            chk({p, "_we"}, 32'(DMEM_WE), 32'(v.st));
            chk({p, "_be"}, 32'(DMEM_BE), 32'(v.exp_be));
            if (v.st) chk({p, "_wdata"}, DMEM_WDATA, v.exp_wd);
            @(posedge CLK); #1;
            chk({p, "_valid_end"}, 32'(LOAD_VALID), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t lw;
        int reqc;
        //           st    f3      addr           wd             rd             w  mis  exp_rd         exp_wd         be
        vecs[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_0011, 0, 1'b0, 32'hFFFF_FF80, 32'h0,         4'b1111};
        vecs[1]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,         32'h9ABC_1234, 3, 1'b0, 32'h0000_9ABC, 32'h0,         4'b1111};
        vecs[2]  = '{1'b0, 3'b001, 32'h0000_2002, 32'h0,         32'h9ABC_1234, 3, 1'b0, 32'hFFFF_9ABC, 32'h0,         4'b1111};
        vecs[3]  = '{1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h0,         0, 1'b0, 32'h0,         32'hA5A5_A5A5, 4'b0010};
        vecs[4]  = '{1'b1, 3'b001, 32'h0000_3002, 32'h1234_BEEF, 32'h0,         1, 1'b0, 32'h0,         32'hBEEF_BEEF, 4'b1100};
        vecs[5]  = '{1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,         2, 1'b0, 32'h0,         32'hCAFE_F00D, 4'b1111};
        vecs[6]  = '{1'b1, 3'b010, 32'h0000_4002, 32'h1111_1111, 32'h0,         0, 1'b1, 32'h0,         32'h0,         4'b0000};
        vecs[7]  = '{1'b0, 3'b001, 32'h0000_4001, 32'h0,         32'h0,         0, 1'b1, 32'h0,         32'h0,         4'b0000};
        vecs[8]  = '{1'b0, 3'b011, 32'h0000_4000, 32'h0,         32'h0,         0, 1'b1, 32'h0,         32'h0,         4'b0000};
        vecs[9]  = '{1'b1, 3'b100, 32'h0000_4000, 32'h2222_2222, 32'h0,         0, 1'b1, 32'h0,         32'h0,         4'b0000};
        vecs[10] = '{1'b0, 3'b100, 32'h0000_1002, 32'h0,         32'h80FF_0011, 1, 1'b0, 32'h0000_00FF, 32'h0,         4'b1111};
        vecs[11] = '{1'b1, 3'b000, 32'h0000_3003, 32'h0000_005A, 32'h0,         0, 1'b0, 32'h0,         32'h5A5A_5A5A, 4'b1000};
        vecs[12] = '{1'b0, 3'b010, 32'h0000_5004, 32'h0,         32'h89AB_CDEF, 2, 1'b0, 32'h89AB_CDEF, 32'h0,         4'b1111};

        RESET = 1'b0;
        idle_inputs();
        DMEM_RDATA = 32'h0;
        DMEM_ACK   = 1'b0;
        prev_rd    = 32'h0;
        #12;
        chk_all_zero("reset");
        RESET = 1'b1;
        @(posedge CLK); #1;

        // SW in flight, reset pulsed between edges.
        MEM_WRITE  = 1'b1;
        FUNCT3     = 3'b010;
        ADDRESS    = 32'h0000_6000;
        WRITE_DATA = 32'h1122_3344;
        @(posedge CLK); #1;
        idle_inputs();
        #1;
        chk("midrst_req_before", 32'(DMEM_REQ), 32'd1);
        chk("midrst_we_before", 32'(DMEM_WE), 32'd1);
        RESET = 1'b0;
        #1;
        chk_all_zero("midrst");
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        lw = '{1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 32'h0BAD_F00D, 32'h0, 4'b1111};
        run_access(lw, 99);

        for (int i = 0; i < 13; i++) begin
            run_access(vecs[i], i);
        end

        // Timeout on the TIMEOUT=4 instance; the default instance keeps waiting.
        chk("to_pre_rdata", t_READ_DATA, 32'h89AB_CDEF);
        MEM_READ = 1'b1;
        FUNCT3   = 3'b010;
        ADDRESS  = 32'h0000_7000;
        DMEM_ACK = 1'b0;
        #1;
        chk("to_busy_req", 32'(t_BUSYWAIT), 32'd1);
        @(posedge CLK); #1;
        idle_inputs();
        reqc = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (t_DMEM_REQ) reqc++;
            @(posedge CLK); #1;
        end
        #1;
        chk("to_req_cycles", 32'(reqc), 32'd4);
        chk("to_req_done", 32'(t_DMEM_REQ), 32'd0);
        chk("to_bus_error", 32'(t_BUS_ERROR), 32'd1);
        chk("to_rdata_zero", t_READ_DATA, 32'd0);
        chk("to_valid", 32'(t_LOAD_VALID), 32'd0);
        chk("to_busy_done", 32'(t_BUSYWAIT), 32'd0);
        chk("main_no_bus_error", 32'(BUS_ERROR), 32'd0);
        chk("main_still_req", 32'(DMEM_REQ), 32'd1);
        @(posedge CLK); #1;
        chk("to_bus_error_end", 32'(t_BUS_ERROR), 32'd0);
        DMEM_ACK   = 1'b1;
        DMEM_RDATA = 32'h5555_5555;
        @(posedge CLK); #1;
        DMEM_ACK = 1'b0;
        #1;
        chk("to_late_ack_valid", 32'(t_LOAD_VALID), 32'd0);
        chk("to_late_ack_rdata", t_READ_DATA, 32'd0);
        chk("to_late_ack_req", 32'(t_DMEM_REQ), 32'd0);
        chk("main_long_valid", 32'(LOAD_VALID), 32'd1);
        chk("main_long_rdata", READ_DATA, 32'h5555_5555);
        @(posedge CLK); #1;
        @(posedge CLK); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
